// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (the adder) returns registered results.
interface full_adder_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             out_valid;
   logic             overflow;

   modport master (
      output in_valid, A, B, Cin,
      input  Sum, Cout, out_valid, overflow
   );

   modport slave (
      input  in_valid, A, B, Cin,
      output Sum, Cout, out_valid, overflow
   );
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder built from a chain of 1-bit full-adder cells.
// Result, carry out and signed overflow appear one clock after the operands.
module full_adder #(
   parameter int WIDTH = 1
) (
   input logic         clk,
   input logic         rst,
   full_adder_if.slave bus
);
   logic [WIDTH-1:0] sum_bits;
   logic             carry_msb;
   logic             carry_out;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             overflow_q;
   logic             valid_q;

   // The carry ripples through a local variable, so the whole chain settles within one cycle.
   always_comb begin
      logic carry;
      sum_bits  = '0;
      carry_msb = 1'b0;
      carry     = bus.Cin;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == WIDTH - 1) begin
            carry_msb = carry;
         end
         sum_bits[i] = bus.A[i] ^ bus.B[i] ^ carry;
         carry       = (bus.A[i] & bus.B[i]) | (bus.A[i] & carry) | (bus.B[i] & carry);
      end
      carry_out = carry;
   end

   // Reset wins over a simultaneous valid; idle cycles keep the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q      <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q      <= sum_bits;
            cout_q     <= carry_out;
            overflow_q <= carry_msb ^ carry_out;
         end
      end
   end

   assign bus.Sum       = sum_q;
   assign bus.Cout      = cout_q;
   assign bus.overflow  = overflow_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a 1-bit and an 8-bit instance checked every cycle
// against an arithmetic model, plus directed vectors with literal results.
module tb_full_adder;
   logic clk;
   logic rst;
   int   num_checks;
   int   num_fails;

   full_adder_if #(.WIDTH(1)) bus1 ();
   full_adder_if #(.WIDTH(8)) bus8 ();

   full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Golden arithmetic: unsigned total for Sum/Cout, signed range test for overflow.
   function automatic void golden(input int w, input int a, input int b, input int cin,
                                  output int s, output int co, output bit ov);
      int full;
      int half;
      int total;
      int sa;
      int sb;
      int st;
      full  = 1 << w;
      half  = 1 << (w - 1);
      total = a + b + cin;
      sa    = (a >= half) ? a - full : a;
      sb    = (b >= half) ? b - full : b;
      st    = sa + sb + cin;
      s     = total % full;
      co    = total / full;
      ov    = (st >= half) || (st < -half);
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   int m1_sum, m1_cout, m8_sum, m8_cout;
   bit m1_ovf, m1_valid, m8_ovf, m8_valid;
   bit armed = 1'b0;

   always @(posedge clk) begin
      int s1, c1, s8, c8;
      bit o1, o8;
      if (rst) begin
         armed    <= 1'b1;
         m1_sum   <= 0;
         m1_cout  <= 0;
         m1_ovf   <= 1'b0;
         m1_valid <= 1'b0;
         m8_sum   <= 0;
         m8_cout  <= 0;
         m8_ovf   <= 1'b0;
         m8_valid <= 1'b0;
      end else begin
         m1_valid <= bus1.in_valid;
         m8_valid <= bus8.in_valid;
         if (bus1.in_valid) begin
            golden(1, int'(bus1.A), int'(bus1.B), int'(bus1.Cin), s1, c1, o1);
            m1_sum  <= s1;
            m1_cout <= c1;
            m1_ovf  <= o1;
         end
         if (bus8.in_valid) begin
            golden(8, int'(bus8.A), int'(bus8.B), int'(bus8.Cin), s8, c8, o8);
            m8_sum  <= s8;
            m8_cout <= c8;
            m8_ovf  <= o8;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         checkOutput("w1_sum",   longint'(bus1.Sum),       longint'(m1_sum));
         checkOutput("w1_cout",  longint'(bus1.Cout),      longint'(m1_cout));
         checkOutput("w1_ovf",   longint'(bus1.overflow),  longint'(m1_ovf));
         checkOutput("w1_valid", longint'(bus1.out_valid), longint'(m1_valid));
         checkOutput("w8_sum",   longint'(bus8.Sum),       longint'(m8_sum));
         checkOutput("w8_cout",  longint'(bus8.Cout),      longint'(m8_cout));
         checkOutput("w8_ovf",   longint'(bus8.overflow),  longint'(m8_ovf));
         checkOutput("w8_valid", longint'(bus8.out_valid), longint'(m8_valid));
      end
   end

   task automatic applyStimulus(input bit r,
                                input bit v1, input bit a1, input bit b1, input bit c1,
                                input bit v8, input logic [7:0] a8, input logic [7:0] b8, input bit c8);
      rst           = r;
      bus1.in_valid = v1;
      bus1.A        = a1;
      bus1.B        = b1;
      bus1.Cin      = c1;
      bus8.in_valid = v8;
      bus8.A        = a8;
      bus8.B        = b8;
      bus8.Cin      = c8;
      @(posedge clk);
      #1;
   endtask

   int exp_sum1[8]  = '{0, 1, 1, 0, 1, 0, 0, 1};
   int exp_cout1[8] = '{0, 0, 0, 1, 0, 1, 1, 1};

   initial begin
      int s, co;
      bit ov;
      logic [2:0] vec;
      num_checks = 0;
      num_fails  = 0;

      golden(8, 8'h7F, 8'h01, 0, s, co, ov);
      checkOutput("model_7f_sum", longint'(s), 64'h80);
      checkOutput("model_7f_ovf", longint'(ov), 64'h1);
      golden(1, 1, 1, 1, s, co, ov);
      checkOutput("model_w1_111_cout", longint'(co), 64'h1);
      checkOutput("model_w1_111_ovf", longint'(ov), 64'h0);

      // Reset held with live operands: everything must stay cleared.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
      checkOutput("rst_sum",   longint'(bus1.Sum),       0);
      checkOutput("rst_cout",  longint'(bus1.Cout),      0);
      checkOutput("rst_ovf",   longint'(bus1.overflow),  0);
      checkOutput("rst_valid", longint'(bus1.out_valid), 0);
      checkOutput("rst_sum8",  longint'(bus8.Sum),       0);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("post_rst_sum",  longint'(bus1.Sum),  1);
      checkOutput("post_rst_cout", longint'(bus1.Cout), 1);

      for (int i = 0; i < 8; i++) begin
         vec = 3'(i);
         applyStimulus(1'b0, 1'b1, vec[2], vec[1], vec[0], 1'b0, 8'h00, 8'h00, 1'b0);
         checkOutput($sformatf("truth_sum_%0d", i),  longint'(bus1.Sum),       longint'(exp_sum1[i]));
         checkOutput($sformatf("truth_cout_%0d", i), longint'(bus1.Cout),      longint'(exp_cout1[i]));
         checkOutput($sformatf("truth_vld_%0d", i),  longint'(bus1.out_valid), 1);
      end

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
         checkOutput("hold_sum",   longint'(bus1.Sum),       1);
         checkOutput("hold_cout",  longint'(bus1.Cout),      0);
         checkOutput("hold_valid", longint'(bus1.out_valid), 0);
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
      checkOutput("ripple_sum",  longint'(bus8.Sum),      64'h00);
      checkOutput("ripple_cout", longint'(bus8.Cout),     1);
      checkOutput("ripple_ovf",  longint'(bus8.overflow), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      checkOutput("max_sum",  longint'(bus8.Sum),  64'hFF);
      checkOutput("max_cout", longint'(bus8.Cout), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
      checkOutput("pos_ovf_sum",  longint'(bus8.Sum),      64'h80);
      checkOutput("pos_ovf_cout", longint'(bus8.Cout),     0);
      checkOutput("pos_ovf_ovf",  longint'(bus8.overflow), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
      checkOutput("neg_ovf_sum",  longint'(bus8.Sum),      64'h00);
      checkOutput("neg_ovf_cout", longint'(bus8.Cout),     1);
      checkOutput("neg_ovf_ovf",  longint'(bus8.overflow), 1);

      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                       1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      checkOutput("stream_valid", longint'(bus8.out_valid), 1);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
      $finish;
   end
endmodule
